// File: rtl/bch_syndrome_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : bch_syndrome_gen_if
//  Description : Bundle of the received-bit input stream and the syndrome
//                output stream of the BCH(15,k) syndrome generator.
//                master : upstream / observer side (drives in_valid, in_bit)
//                slave  : syndrome generator side (drives busy and out_*)
//  Signals     : in_valid      qualifies in_bit, CW_LEN consecutive cycles
//                in_bit        received bit, r14 first, r0 last
//                busy          generator accumulating or streaming
//                out_valid     one cycle per syndrome, NUM_SYN per frame
//                out_syndrome  S1..S(NUM_SYN), zero when out_valid is low
//                out_clean     frame had all-zero syndromes
//  Revision    : 1.0 - initial release
// ============================================================================
interface bch_syndrome_gen_if;
    logic       in_valid;
    logic       in_bit;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_syndrome;
    logic       out_clean;

    modport master (
        output in_valid,
        output in_bit,
        input  busy,
        input  out_valid,
        input  out_syndrome,
        input  out_clean
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        output busy,
        output out_valid,
        output out_syndrome,
        output out_clean
    );
endinterface
`default_nettype wire

// File: rtl/bch_syndrome_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bch_syndrome_gen
//  Description : BCH(15,k) syndrome generator over GF(2^4), p(x)=x^4+x+1.
//                Accepts a 15-bit received word serially (r14 first) and
//                evaluates S_j = r(alpha^j), j=1..2T, by Horner's rule, then
//                streams the syndromes one per cycle, S1 first.
//  Ports       : clk      clock, rising edge
//                rst      synchronous active-high reset
//                i_if     bch_syndrome_gen_if.slave (in_valid, in_bit, busy,
//                         out_valid, out_syndrome, out_clean)
//  Parameters  : T        correctable errors (1..7), NUM_SYN = 2*T
//                CW_LEN   codeword length, only 15 is supported
//  Options     : SYN_POWER_FORM_EN - when defined, out_syndrome carries the
//                exponent e of alpha^e (15 encodes zero) via a log table.
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_syndrome_gen #(
    parameter int T      = 3,
    parameter int CW_LEN = 15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bch_syndrome_gen_if.slave i_if
);

    localparam int         c_NUM_SYN  = 2 * T;
    localparam logic [3:0] c_LAST_BIT = 4'(CW_LEN - 1);
    localparam logic [3:0] c_LAST_IDX = 4'(c_NUM_SYN - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_OUT  = 2'd2;

    // Multiply a field element by alpha^n. With n constant this collapses to
    // a fixed XOR matrix: each step is a left shift with x^4 folded back as
    // x+1.
    function automatic logic [3:0] f_mul_alpha_pow(input logic [3:0] x, input int n);
        logic [3:0] v;
        v = x;
        for (int k = 0; k < n; k++) begin
            v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
        end
        return v;
    endfunction

`ifdef SYN_POWER_FORM_EN
    // Discrete log: walks alpha^0..alpha^14; zero has no log and maps to 15.
    function automatic logic [3:0] f_gf_log(input logic [3:0] x);
        logic [3:0] p;
        logic [3:0] e_out;
        p     = 4'd1;
        e_out = 4'd15;
        for (int e = 0; e < 15; e++) begin
            if (p == x) begin
                e_out = 4'(e);
            end
            p = f_mul_alpha_pow(p, 1);
        end
        return e_out;
    endfunction
`endif

    logic [1:0]                  r_state;
    logic [1:0]                  w_next_state;
    logic [c_NUM_SYN-1:0][3:0]   r_syn;
    logic [c_NUM_SYN-1:0][3:0]   w_acc;
    logic [3:0]                  r_bit_cnt;
    logic [3:0]                  r_out_idx;
    logic                        r_clean;
    logic [3:0]                  w_sel;
    logic                        w_last_bit;
    logic                        w_out_last;

    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);
    assign w_out_last = (r_out_idx == c_LAST_IDX);

    // One Horner step per syndrome: S_j <- S_j * alpha^j + r_i
    for (genvar g = 0; g < c_NUM_SYN; g++) begin : g_syn
        assign w_acc[g] = f_mul_alpha_pow(r_syn[g], g + 1) ^ {3'b000, i_if.in_bit};
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_if.in_valid) begin
                    w_next_state = c_ACC;
                end
            end
            c_ACC: begin
                // A gap in in_valid mid-frame abandons the frame.
                if (!i_if.in_valid) begin
                    w_next_state = c_IDLE;
                end else if (w_last_bit) begin
                    w_next_state = c_OUT;
                end
            end
            c_OUT: begin
                if (w_out_last) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_syn     <= '0;
            r_bit_cnt <= 4'd0;
            r_out_idx <= 4'd0;
            r_clean   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_if.in_valid) begin
                        // First bit seeds every accumulator (Horner start).
                        r_syn     <= {c_NUM_SYN{3'b000, i_if.in_bit}};
                        r_bit_cnt <= 4'd1;
                        r_out_idx <= 4'd0;
                        r_clean   <= 1'b0;
                    end
                end
                c_ACC: begin
                    if (i_if.in_valid) begin
                        r_syn     <= w_acc;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        // Cleanliness is captured from the final syndromes
                        // as they are written, and then held for the burst.
                        if (w_last_bit) begin
                            r_clean <= (w_acc == '0);
                        end
                    end
                end
                c_OUT: begin
                    r_out_idx <= r_out_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Syndrome selector; the compare loop avoids indexing a non-power-of-two
    // array with a wider counter.
    always_comb begin
        w_sel = 4'd0;
        for (int k = 0; k < c_NUM_SYN; k++) begin
            if (r_out_idx == 4'(k)) begin
                w_sel = r_syn[k];
            end
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        i_if.busy         = (r_state != c_IDLE);
        i_if.out_valid    = (r_state == c_OUT);
        i_if.out_clean    = (r_state == c_OUT) && r_clean;
        i_if.out_syndrome = 4'd0;
        if (r_state == c_OUT) begin
`ifdef SYN_POWER_FORM_EN
            i_if.out_syndrome = f_gf_log(w_sel);
`else
            i_if.out_syndrome = w_sel;
`endif
        end
    end

endmodule
`default_nettype wire
